// File: rtl/m72_pkg.sv
// Shared types for the SDRAM request arbiter: FSM state encoding and counter width.
package m72_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    // Wide enough for the largest supported TIMEOUT (1023).
    localparam int CNT_W = 10;

endpackage

// File: rtl/sdr_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or after start, wrapping.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [PTR_W-1:0]  start,
    output logic [PTR_W-1:0]  idx,
    output logic              valid
);

    int j;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = (int'(start) + k) % NUM_CH;
            if (!valid && mask[j]) begin
                valid = 1'b1;
                idx   = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/sdr_req_arbiter.sv
// Round-robin arbiter funnelling per-channel word requests onto a single SDRAM
// controller port, with one outstanding transaction and a WAIT-state timeout.
module sdr_req_arbiter
    import m72_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                           CLK_96M,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              ch_req,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_din,
    input  logic [NUM_CH-1:0][1:0]         ch_wr_sel,
    input  logic [NUM_CH-1:0]              ch_writable,
    output logic [NUM_CH-1:0]              ch_ack,
    output logic [DATA_W-1:0]              ch_dout,
    output logic [ADDR_W-1:0]              sdr_addr,
    output logic [DATA_W-1:0]              sdr_din,
    output logic [1:0]                     sdr_wr_sel,
    output logic                           sdr_req,
    input  logic                           sdr_rdy,
    input  logic [DATA_W-1:0]              sdr_dout,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int PTR_W = $clog2(NUM_CH);

    arb_state_t          state;
    logic [NUM_CH-1:0]   pend;
    logic [NUM_CH-1:0]   req_mask;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic                pick_vld;
    logic                can_grant;
    logic                expired;
    logic [CNT_W-1:0]    cnt;

    // A request arriving this cycle is visible to the picker immediately,
    // so an idle arbiter issues sdr_req on the very next cycle.
    assign req_mask = pend | ch_req;

    rr_pick #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_pick (
        .mask  (req_mask),
        .start (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    // No grant during the ack cycle: guarantees one idle cycle before the next sdr_req.
    assign can_grant = (state == ARB_IDLE) && (ch_ack == '0) && pick_vld;
    assign expired   = (cnt == CNT_W'(TIMEOUT - 1));
    assign next_ptr  = (grant == PTR_W'(NUM_CH - 1)) ? '0 : grant + PTR_W'(1);

    always_ff @(posedge CLK_96M) begin
        if (reset) begin
            state       <= ARB_IDLE;
            pend        <= '0;
            rr_ptr      <= '0;
            grant       <= '0;
            cnt         <= '0;
            sdr_req     <= 1'b0;
            ch_ack      <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            sdr_wr_sel  <= 2'b00;
            sdr_addr    <= '0;
            sdr_din     <= '0;
            ch_dout     <= '0;
        end else begin
            // Set wins over the ack-driven clear.
            pend        <= (pend & ~ch_ack) | ch_req;
            sdr_req     <= 1'b0;
            ch_ack      <= '0;
            timeout_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (can_grant) begin
                        state      <= ARB_WAIT;
                        grant      <= pick_idx;
                        cnt        <= '0;
                        sdr_addr   <= ch_addr[pick_idx];
                        sdr_din    <= ch_din[pick_idx];
                        sdr_wr_sel <= ch_writable[pick_idx] ? ch_wr_sel[pick_idx] : 2'b00;
                        sdr_req    <= 1'b1;
                        busy       <= 1'b1;
                    end else if (ch_ack != '0) begin
                        busy <= 1'b0;
                    end
                end
                ARB_WAIT: begin
                    if (sdr_rdy || expired) begin
                        ch_dout       <= sdr_rdy ? sdr_dout : '1;
                        timeout_err   <= !sdr_rdy;
                        ch_ack[grant] <= 1'b1;
                        rr_ptr        <= next_ptr;
                        state         <= ARB_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_req_arbiter.sv
// Directed bench for sdr_req_arbiter: read, fairness, write masking, timeout,
// reset mid-transaction and request/ack collision, all with cycle-exact checks.
module tb_sdr_req_arbiter;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic                           clk;
    logic                           reset;
    logic [NUM_CH-1:0]              ch_req;
    logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr;
    logic [NUM_CH-1:0][DATA_W-1:0]  ch_din;
    logic [NUM_CH-1:0][1:0]         ch_wr_sel;
    logic [NUM_CH-1:0]              ch_writable;
    logic [NUM_CH-1:0]              ch_ack;
    logic [DATA_W-1:0]              ch_dout;
    logic [ADDR_W-1:0]              sdr_addr;
    logic [DATA_W-1:0]              sdr_din;
    logic [1:0]                     sdr_wr_sel;
    logic                           sdr_req;
    logic                           sdr_rdy;
    logic [DATA_W-1:0]              sdr_dout;
    logic                           busy;
    logic                           timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    sdr_req_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_96M     (clk),
        .reset       (reset),
        .ch_req      (ch_req),
        .ch_addr     (ch_addr),
        .ch_din      (ch_din),
        .ch_wr_sel   (ch_wr_sel),
        .ch_writable (ch_writable),
        .ch_ack      (ch_ack),
        .ch_dout     (ch_dout),
        .sdr_addr    (sdr_addr),
        .sdr_din     (sdr_din),
        .sdr_wr_sel  (sdr_wr_sel),
        .sdr_req     (sdr_req),
        .sdr_rdy     (sdr_rdy),
        .sdr_dout    (sdr_dout),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        ch_req      = '0;
        ch_din      = '0;
        ch_wr_sel   = '0;
        ch_writable = '1;
        sdr_rdy     = 1'b0;
        sdr_dout    = '0;
        for (int i = 0; i < NUM_CH; i++) ch_addr[i] = ADDR_W'(24'h000100 * (i + 1));
        do_reset();

        // Reset state
        chk("rst_sdr_req", 32'(sdr_req), 0);
        chk("rst_ch_ack", 32'(ch_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        chk("rst_wr_sel", 32'(sdr_wr_sel), 0);
        chk("rst_addr", 32'(sdr_addr), 0);
        chk("rst_dout", 32'(ch_dout), 0);

        // Single read on channel 1
        ch_addr[1] = 24'h012340;
        ch_req = 4'b0010;                                  // cycle 0
        tick();
        ch_req = '0;                                       // cycle 1
        chk("rd_sdr_req", 32'(sdr_req), 1);
        chk("rd_addr", 32'(sdr_addr), 32'h012340);
        chk("rd_wr_sel", 32'(sdr_wr_sel), 0);
        chk("rd_busy", 32'(busy), 1);
        tick();                                            // cycle 2
        chk("rd_req_pulse", 32'(sdr_req), 0);
        tick(); tick(); tick();                            // cycle 5
        sdr_rdy = 1'b1; sdr_dout = 16'hBEEF;
        chk("rd_no_early_ack", 32'(ch_ack), 0);
        tick();                                            // cycle 6
        sdr_rdy = 1'b0;
        chk("rd_ack", 32'(ch_ack), 32'b0010);
        chk("rd_dout", 32'(ch_dout), 32'hBEEF);
        chk("rd_busy_ack", 32'(busy), 1);
        chk("rd_tmo", 32'(timeout_err), 0);
        // Stray sdr_rdy while idle must be ignored
        sdr_rdy = 1'b1; sdr_dout = 16'h1234;
        tick();                                            // cycle 7
        sdr_rdy = 1'b0;
        chk("rd_ack_pulse", 32'(ch_ack), 0);
        chk("rd_busy_done", 32'(busy), 0);
        tick();
        chk("idle_rdy_ack", 32'(ch_ack), 0);
        chk("idle_rdy_dout", 32'(ch_dout), 32'hBEEF);

        // Fairness and collision: ch0+ch2 together, ch0 re-requests in its ack cycle
        do_reset();
        ch_addr[1] = 24'h000200;
        ch_req = 4'b0101;
        tick();
        ch_req = '0;
        chk("fair1_req", 32'(sdr_req), 1);
        chk("fair1_addr", 32'(sdr_addr), 32'h000100);
        sdr_rdy = 1'b1; sdr_dout = 16'h1111;
        tick();
        sdr_rdy = 1'b0;
        chk("fair1_ack", 32'(ch_ack), 32'b0001);
        ch_req = 4'b0001;
        tick();
        ch_req = '0;
        chk("turnaround", 32'(sdr_req), 0);
        tick();
        chk("fair2_req", 32'(sdr_req), 1);
        chk("fair2_addr", 32'(sdr_addr), 32'h000300);
        sdr_rdy = 1'b1; sdr_dout = 16'h2222;
        tick();
        sdr_rdy = 1'b0;
        chk("fair2_ack", 32'(ch_ack), 32'b0100);
        tick();
        tick();
        chk("fair3_req", 32'(sdr_req), 1);
        chk("fair3_addr", 32'(sdr_addr), 32'h000100);
        sdr_rdy = 1'b1; sdr_dout = 16'h3333;
        tick();
        sdr_rdy = 1'b0;
        chk("fair3_ack", 32'(ch_ack), 32'b0001);
        chk("fair3_dout", 32'(ch_dout), 32'h3333);
        tick(); tick(); tick();
        chk("fair_drained", 32'(sdr_req), 0);
        chk("fair_idle", 32'(busy), 0);

        // Write masking on channel 3
        ch_wr_sel[3] = 2'b11; ch_din[3] = 16'hA5A5; ch_writable[3] = 1'b0;
        ch_req = 4'b1000;
        tick();
        ch_req = '0;
        chk("wm0_req", 32'(sdr_req), 1);
        chk("wm0_wr_sel", 32'(sdr_wr_sel), 0);
        sdr_rdy = 1'b1;
        tick();
        sdr_rdy = 1'b0;
        chk("wm0_ack", 32'(ch_ack), 32'b1000);
        tick();
        ch_writable[3] = 1'b1;
        ch_req = 4'b1000;
        tick();
        ch_req = '0;
        chk("wm1_req", 32'(sdr_req), 1);
        chk("wm1_wr_sel", 32'(sdr_wr_sel), 32'b11);
        chk("wm1_din", 32'(sdr_din), 32'hA5A5);
        sdr_rdy = 1'b1;
        tick();
        sdr_rdy = 1'b0;
        chk("wm1_ack", 32'(ch_ack), 32'b1000);
        tick(); tick();

        // Timeout on channel 0 with channel 1 waiting behind it
        ch_wr_sel[3] = 2'b00;
        ch_req = 4'b0011;
        tick();
        ch_req = '0;                                       // sdr_req cycle
        chk("tmo_req", 32'(sdr_req), 1);
        chk("tmo_addr", 32'(sdr_addr), 32'h000100);
        for (int c = 1; c < TIMEOUT; c++) tick();
        chk("tmo_no_early_ack", 32'(ch_ack), 0);
        tick();                                            // TIMEOUT cycles after sdr_req
        chk("tmo_ack", 32'(ch_ack), 32'b0001);
        chk("tmo_err", 32'(timeout_err), 1);
        chk("tmo_dout", 32'(ch_dout), 32'hFFFF);
        tick();
        chk("tmo_err_pulse", 32'(timeout_err), 0);
        chk("tmo_turnaround", 32'(sdr_req), 0);
        tick();
        chk("tmo_next_req", 32'(sdr_req), 1);
        chk("tmo_next_addr", 32'(sdr_addr), 32'h000200);
        sdr_rdy = 1'b1; sdr_dout = 16'h4444;
        tick();
        sdr_rdy = 1'b0;
        chk("tmo_next_ack", 32'(ch_ack), 32'b0010);
        chk("tmo_next_err", 32'(timeout_err), 0);
        tick(); tick();

        // Reset while in WAIT, then a late sdr_rdy
        ch_req = 4'b0100;
        tick();
        ch_req = '0;
        chk("rw_req", 32'(sdr_req), 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_busy", 32'(busy), 0);
        sdr_rdy = 1'b1; sdr_dout = 16'hDEAD;
        tick();
        sdr_rdy = 1'b0;
        chk("rw_no_ack", 32'(ch_ack), 0);
        chk("rw_dout", 32'(ch_dout), 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rw_no_req", 32'(sdr_req), 0);
            chk("rw_quiet_ack", 32'(ch_ack), 0);
        end
        chk("rw_busy_end", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdr_req_arbiter.md
SDR_REQ_ARBITER -- requirements
Module: sdr_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels, range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 24: SDRAM word-address width (bits [ADDR_W:1]).
REQ-003 SHALL have parameter DATA_W, default 16: data width.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before abort, range 4..1023.
REQ-005 SHALL have one clock and a synchronous, active-high reset: CLK_96M  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port ch_req  in  NUM_CH  per-channel one-cycle request pulse.
REQ-008 SHALL have port ch_addr  in  NUM_CH*ADDR_W  per-channel word address, held stable from ch_req until ch_ack.
REQ-009 SHALL have port ch_din  in  NUM_CH*DATA_W  per-channel write data, held stable from ch_req until ch_ack.
REQ-010 SHALL have port ch_wr_sel  in  NUM_CH*2  per-channel byte write enables; 00 means read.
REQ-011 SHALL have port ch_writable  in  NUM_CH  per-channel region-writable qualifier.
REQ-012 SHALL have port ch_ack  out  NUM_CH  one-cycle completion pulse per channel.
REQ-013 SHALL have port ch_dout  out  DATA_W  read data, shared by all channels, valid while ch_ack is high and held after.
REQ-014 SHALL have ports sdr_addr  out  ADDR_W, sdr_din  out  DATA_W, sdr_wr_sel  out  2, sdr_req  out  1 (one-cycle pulse).
REQ-015 SHALL have ports sdr_rdy  in  1 and sdr_dout  in  DATA_W: completion strobe and data from the SDRAM controller.
REQ-016 SHALL have ports busy  out  1 (a transaction is outstanding) and timeout_err  out  1 (one-cycle abort pulse).

Function
REQ-017 SHALL latch each ch_req pulse into pend[i]; pend[i] is cleared only when ch_ack[i] fires.
REQ-018 SHALL ignore a further ch_req[i] while pend[i] is already set, with no queuing depth beyond one.
REQ-019 SHALL give set priority when ch_req[i] coincides with ch_ack[i], leaving pend[i] set.
REQ-020 SHALL use states IDLE and WAIT: IDLE moves to WAIT on grant; WAIT moves to IDLE on sdr_rdy or timeout.
REQ-021 SHALL, in IDLE, evaluate (pend | ch_req) round-robin starting at rr_ptr, so that sdr_req is high in the cycle after ch_req when the arbiter is idle.
REQ-022 SHALL, on grant, register sdr_addr/sdr_din/sdr_wr_sel from the granted channel, pulse sdr_req for exactly one cycle, and store grant.
REQ-023 SHALL force sdr_wr_sel to 00 when ch_writable[grant]=0, turning the access into a read.
REQ-024 SHALL, in WAIT on sdr_rdy, register ch_dout<=sdr_dout, pulse ch_ack[grant] in the next cycle, set rr_ptr<=grant+1 (mod NUM_CH), and return to IDLE.
REQ-025 SHALL, in WAIT, count cycles; at TIMEOUT cycles without sdr_rdy it SHALL set ch_dout to all ones, pulse ch_ack[grant] and timeout_err together, advance rr_ptr, and return to IDLE.
REQ-026 SHALL ignore sdr_rdy seen in IDLE.
REQ-027 SHALL drive busy high from the cycle sdr_req is high through the cycle ch_ack is high.
REQ-028 SHALL produce a minimum turnaround of one IDLE cycle between ch_ack and the next sdr_req.

Reset
REQ-029 SHALL, on reset, set state=IDLE, pend=0, rr_ptr=0, grant=0, counter=0, sdr_req=0, ch_ack=0, timeout_err=0, busy=0, sdr_wr_sel=00, sdr_addr=0, sdr_din=0, ch_dout=0.
REQ-030 SHALL, when reset is asserted mid-WAIT, abandon the transaction without any ch_ack, and ignore an sdr_rdy arriving after reset.

Structure
REQ-031 SHALL place the state enum (ARB_IDLE, ARB_WAIT) in m72_pkg.
REQ-032 SHALL implement the round-robin priority picker as sub-module rr_pick (inputs NUM_CH mask and start pointer; outputs index and valid), combinational.

Verification
REQ-033 SHALL verify single read: ch_req[1] at cycle 0 with ch_addr=0x012340 -> sdr_req at cycle 1 with sdr_addr=0x012340 and wr_sel=00; sdr_rdy with dout=0xBEEF at cycle 5 -> ch_ack[1] at cycle 6 with ch_dout=0xBEEF.
REQ-034 SHALL verify fairness: ch_req on channels 0 and 2 in the same cycle, then channel 0 re-requests immediately after its ack -> grant order is 0, 2, 0.
REQ-035 SHALL verify write masking: channel 3 with wr_sel=11, din=0xA5A5, writable=0 -> sdr_wr_sel=00; with writable=1 -> sdr_wr_sel=11 and sdr_din=0xA5A5.
REQ-036 SHALL verify timeout: TIMEOUT=8 and sdr_rdy never arrives -> ch_ack and timeout_err pulse 8 cycles after sdr_req with ch_dout=0xFFFF, and the next pending channel is granted afterwards.
REQ-037 SHALL verify reset mid-WAIT: reset in WAIT followed by sdr_rdy -> no ch_ack fires, busy=0, and pend=0.
REQ-038 SHALL verify collision: ch_req[0] in the same cycle as ch_ack[0] -> pend[0] stays set and a second sdr_req for channel 0 is issued.
